// File: rtl/subtrator_serial_if.sv
// ============================================================================
// Module      : subtrator_serial_if
// Description : Handshake and operand/result bundle for the serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface subtrator_serial_if #(
    parameter int LARGURA = 32
);
    logic               inicio;
    logic [LARGURA-1:0] entrada1;
    logic [LARGURA-1:0] entrada2;
    logic [LARGURA-1:0] resultado;
    logic               emprestimo;
    logic               overflow;
    logic               zero;
    logic               ocupado;
    logic               pronto;

    modport master (
        output inicio,
        output entrada1,
        output entrada2,
        input  resultado,
        input  emprestimo,
        input  overflow,
        input  zero,
        input  ocupado,
        input  pronto
    );

    modport slave (
        input  inicio,
        input  entrada1,
        input  entrada2,
        output resultado,
        output emprestimo,
        output overflow,
        output zero,
        output ocupado,
        output pronto
    );
endinterface

`default_nettype wire

// File: rtl/subtrator_serial.sv
// ============================================================================
// Module      : subtrator_serial
// Description : Multi-cycle subtractor, FATIA bits per clock, LSB slice first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module subtrator_serial #(
    parameter int LARGURA = 32,
    parameter int FATIA   = 8
) (
    input  logic                clock,
    input  logic                reset,
    subtrator_serial_if.slave   bus
);

    localparam int NFATIAS = LARGURA / FATIA;
    localparam int CW      = (NFATIAS > 1) ? $clog2(NFATIAS) : 1;
    localparam logic [CW-1:0] C_ULTIMA = CW'(NFATIAS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIM  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [LARGURA-1:0] r_a;
    logic [LARGURA-1:0] r_b;
    logic [LARGURA-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_borrow;

    logic [LARGURA-1:0] r_resultado;
    logic               r_emprestimo;
    logic               r_overflow;
    logic               r_zero;
    logic               r_ocupado;
    logic               r_pronto;

    logic               w_accept;
    logic               w_last;
    logic [FATIA-1:0]   w_a_sl;
    logic [FATIA-1:0]   w_b_sl;
    logic [FATIA:0]     w_diff;
    logic [LARGURA-1:0] w_acc_next;

    assign w_last = (r_state == CALC) && (r_cnt == C_ULTIMA);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A start is honoured both from IDLE and from FIM, giving back-to-back ops.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.inicio) begin
                    w_accept = 1'b1;
                    w_next   = CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_next = FIM;
                end
            end
            FIM: begin
                if (bus.inicio) begin
                    w_accept = 1'b1;
                    w_next   = CALC;
                end else begin
                    w_next   = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Slice select and (FATIA+1)-bit subtraction; the top bit is the borrow out.
    always_comb begin
        w_a_sl     = '0;
        w_b_sl     = '0;
        w_acc_next = r_acc;
        for (int i = 0; i < NFATIAS; i++) begin
            if (r_cnt == CW'(i)) begin
                w_a_sl = r_a[i*FATIA +: FATIA];
                w_b_sl = r_b[i*FATIA +: FATIA];
            end
        end
        w_diff = {1'b0, w_a_sl} - {1'b0, w_b_sl} - {{FATIA{1'b0}}, r_borrow};
        for (int i = 0; i < NFATIAS; i++) begin
            if (r_cnt == CW'(i)) begin
                w_acc_next[i*FATIA +: FATIA] = w_diff[FATIA-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_borrow     <= 1'b0;
            r_resultado  <= '0;
            r_emprestimo <= 1'b0;
            r_overflow   <= 1'b0;
            r_zero       <= 1'b0;
            r_ocupado    <= 1'b0;
            r_pronto     <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            if (w_accept) begin
                r_a       <= bus.entrada1;
                r_b       <= bus.entrada2;
                r_cnt     <= '0;
                r_borrow  <= 1'b0;
                r_ocupado <= 1'b1;
            end else if (r_state == CALC) begin
                r_acc    <= w_acc_next;
                r_borrow <= w_diff[FATIA];
                r_cnt    <= r_cnt + CW'(1);
                if (w_last) begin
                    r_resultado  <= w_acc_next;
                    r_emprestimo <= w_diff[FATIA];
                    r_overflow   <= (r_a[LARGURA-1] != r_b[LARGURA-1]) &&
                                    (w_acc_next[LARGURA-1] != r_a[LARGURA-1]);
                    r_zero       <= (w_acc_next == '0);
                    r_ocupado    <= 1'b0;
                    r_pronto     <= 1'b1;
                end
            end
        end
    end

    assign bus.resultado  = r_resultado;
    assign bus.emprestimo = r_emprestimo;
    assign bus.overflow   = r_overflow;
    assign bus.zero       = r_zero;
    assign bus.ocupado    = r_ocupado;
    assign bus.pronto     = r_pronto;

endmodule

`default_nettype wire

// File: tb/tb_subtrator_serial.sv
// ============================================================================
// Module      : tb_subtrator_serial
// Description : Self-checking bench for subtrator_serial with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_subtrator_serial;

    logic clock;
    logic reset;
    int   tests_run;
    int   tests_failed;

    subtrator_serial_if #(.LARGURA(32)) bus ();

    subtrator_serial #(.LARGURA(32), .FATIA(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic bo,
                                  output logic ov, output logic z);
        longint sd;
        sd = longint'($signed(a)) - longint'($signed(b));
        d  = a - b;
        bo = (a < b);
        ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        z  = (d == 32'h0);
    endfunction

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        bus.entrada1 = a;
        bus.entrada2 = b;
        bus.inicio   = 1'b1;
        @(negedge clock);
        bus.inicio   = 1'b0;
        bus.entrada1 = $urandom;
        bus.entrada2 = $urandom;
    endtask

    task automatic wait_done(output int lat, output int busy, output bit ok);
        lat  = 0;
        busy = 0;
        ok   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.pronto) begin
                ok = 1'b1;
                break;
            end
            if (bus.ocupado) busy++;
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset      = 1'b1;
        bus.inicio = 1'b1;
        bus.entrada1 = 32'h5;
        bus.entrada2 = 32'h1;
        @(negedge clock);
        @(negedge clock);
        bus.inicio = 1'b0;
        tests_run++;
        if (bus.resultado !== 32'h0 || bus.emprestimo !== 1'b0 || bus.overflow !== 1'b0 ||
            bus.zero !== 1'b0 || bus.ocupado !== 1'b0 || bus.pronto !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got res=%h b=%b v=%b z=%b busy=%b done=%b, need all 0",
                     bus.resultado, bus.emprestimo, bus.overflow, bus.zero, bus.ocupado, bus.pronto);
        end
        reset = 1'b0;
        @(negedge clock);
        tests_run++;
        if (bus.ocupado !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_wins: ocupado=%b, need 0", bus.ocupado);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [6] = '{32'h3, 32'h1, 32'h100, 32'h80000000, 32'h12345678, 32'h7FFFFFFF};
        logic [31:0] vb [6] = '{32'h1, 32'h3, 32'h1,   32'h1,        32'h12345678, 32'hFFFFFFFF};
        logic [31:0] ed;
        logic eb, ev, ez;
        int lat, busy;
        bit ok;
        for (int k = 0; k < 6; k++) begin
            model(va[k], vb[k], ed, eb, ev, ez);
            start_op(va[k], vb[k]);
            wait_done(lat, busy, ok);
            tests_run++;
            if (!ok || lat != 4 || busy != 4) begin
                tests_failed++;
                $display("FAIL dir_timing[%0d]: ok=%0d lat=%0d busy=%0d, need 1/4/4", k, ok, lat, busy);
            end
            tests_run++;
            if (bus.resultado !== ed || bus.emprestimo !== eb || bus.overflow !== ev || bus.zero !== ez) begin
                tests_failed++;
                $display("FAIL dir_result[%0d]: got %h b=%b v=%b z=%b, need %h b=%b v=%b z=%b",
                         k, bus.resultado, bus.emprestimo, bus.overflow, bus.zero, ed, eb, ev, ez);
            end
            @(negedge clock);
            tests_run++;
            if (bus.pronto !== 1'b0 || bus.resultado !== ed) begin
                tests_failed++;
                $display("FAIL dir_pulse_hold[%0d]: pronto=%b res=%h, need 0 and %h", k, bus.pronto, bus.resultado, ed);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, ed, prev;
        logic eb, ev, ez;
        int lat, busy;
        bit ok;
        prev = bus.resultado;
        for (int k = 0; k < 30; k++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = a;
                1: a = 32'h0;
                2: b = 32'hFFFFFFFF;
                3: a = {1'b1, 31'h0};
                default: ;
            endcase
            model(a, b, ed, eb, ev, ez);
            start_op(a, b);
            tests_run++;
            if (bus.resultado !== prev || bus.ocupado !== 1'b1) begin
                tests_failed++;
                $display("FAIL rnd_hold[%0d]: res=%h busy=%b, need %h and 1", k, bus.resultado, bus.ocupado, prev);
            end
            wait_done(lat, busy, ok);
            tests_run++;
            if (!ok || lat != 4 || bus.resultado !== ed || bus.emprestimo !== eb ||
                bus.overflow !== ev || bus.zero !== ez) begin
                tests_failed++;
                $display("FAIL rnd_result[%0d]: %h-%h ok=%0d lat=%0d got %h b=%b v=%b z=%b, need %h b=%b v=%b z=%b",
                         k, a, b, ok, lat, bus.resultado, bus.emprestimo, bus.overflow, bus.zero, ed, eb, ev, ez);
            end
            prev = ed;
            @(negedge clock);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ed;
        logic eb, ev, ez;
        int lat, busy, gap;
        bit ok;
        start_op(32'h12345678, 32'h12345678);
        wait_done(lat, busy, ok);
        tests_run++;
        if (!ok || bus.zero !== 1'b1 || bus.resultado !== 32'h0) begin
            tests_failed++;
            $display("FAIL b2b_first: ok=%0d zero=%b res=%h, need 1/1/0", ok, bus.zero, bus.resultado);
        end
        model(32'h5, 32'h2, ed, eb, ev, ez);
        start_op(32'h5, 32'h2);
        wait_done(lat, busy, ok);
        gap = lat + 1;
        tests_run++;
        if (!ok || gap != 5 || bus.resultado !== ed || bus.zero !== ez || bus.emprestimo !== eb) begin
            tests_failed++;
            $display("FAIL b2b_second: ok=%0d gap=%0d res=%h z=%b, need gap 5 res %h z=%b",
                     ok, gap, bus.resultado, bus.zero, ed, ez);
        end
        @(negedge clock);
    endtask

    task automatic test_busy_ignore();
        int prontos;
        start_op(32'hA, 32'h4);
        @(negedge clock);
        bus.entrada1 = 32'h100;
        bus.entrada2 = 32'h7;
        bus.inicio   = 1'b1;
        @(negedge clock);
        bus.inicio   = 1'b0;
        prontos = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.pronto) begin
                prontos++;
                tests_run++;
                if (bus.resultado !== 32'h6) begin
                    tests_failed++;
                    $display("FAIL busy_result: got %h, need 00000006", bus.resultado);
                end
            end
            @(negedge clock);
        end
        tests_run++;
        if (prontos != 1) begin
            tests_failed++;
            $display("FAIL busy_pronto_count: got %0d, need 1", prontos);
        end
    endtask

    task automatic test_reset_mid_op();
        int prontos, lat, busy;
        bit ok;
        start_op(32'h0000FFFF, 32'h00000001);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tests_run++;
        if (bus.resultado !== 32'h0 || bus.emprestimo !== 1'b0 || bus.overflow !== 1'b0 ||
            bus.zero !== 1'b0 || bus.ocupado !== 1'b0 || bus.pronto !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_state: res=%h b=%b v=%b z=%b busy=%b done=%b, need all 0",
                     bus.resultado, bus.emprestimo, bus.overflow, bus.zero, bus.ocupado, bus.pronto);
        end
        prontos = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.pronto || bus.ocupado) prontos++;
            @(negedge clock);
        end
        tests_run++;
        if (prontos != 0) begin
            tests_failed++;
            $display("FAIL midreset_quiet: activity cycles=%0d, need 0", prontos);
        end
        start_op(32'h7, 32'h7);
        wait_done(lat, busy, ok);
        tests_run++;
        if (!ok || lat != 4 || bus.zero !== 1'b1 || bus.resultado !== 32'h0) begin
            tests_failed++;
            $display("FAIL midreset_after: ok=%0d lat=%0d zero=%b res=%h, need 1/4/1/0",
                     ok, lat, bus.zero, bus.resultado);
        end
        @(negedge clock);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        bus.inicio   = 1'b0;
        bus.entrada1 = '0;
        bus.entrada2 = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
